sp_port_arbiter: RTL and testbench
==================================

# sp_port_arbiter

Parametrised N-master front end for one Gowin single-port block RAM (fft0/fft1/adc buffers). It is the sequential successor to the static 3-way RAM port mux. It grants exactly one master at a time, via an external select or round-robin on requests. It drains in-flight reads before any hand-over and returns a per-master read-valid pulse aligned to the RAM read latency.

## Interface
Parameters:
- N_MASTERS, 3, number of masters (2..8)
- ADDR_W, 11, RAM address width
- DATA_W, 32, RAM data width
- READ_LAT, 2, cycles from ce&~wre issue to valid dout (1..4; 2 = output-register mode)
- MODE, 0, 0 = select-driven ownership, 1 = round-robin on req

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sel  in  $clog2(N_MASTERS)  target master (MODE 0 only)
- req  in  N_MASTERS  per-master access request, level
- grant  out  N_MASTERS  one-hot ownership, registered
- m_oce, m_ce, m_wre  in  N_MASTERS each  per-master RAM controls
- m_ad  in  N_MASTERS*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
- m_din  in  N_MASTERS*DATA_W  packed write data
- m_rvalid  out  N_MASTERS  one-cycle pulse, read data valid for master k
- rdata  out  DATA_W  read data = ram_dout, broadcast
- ram_oce, ram_ce, ram_wre  out  1 each  to RAM
- ram_ad  out  ADDR_W  to RAM
- ram_din  out  DATA_W  to RAM
- ram_dout  in  DATA_W  from RAM

## Operation
- FSM states IDLE, OWN, DRAIN; owner index register; last-owner register (round-robin pointer).
- IDLE:
  - MODE 0: if sel < N_MASTERS and req[sel] → owner=sel, grant[sel]=1, go OWN.
  - MODE 1: pick the first k with req[k]=1, searching from last_owner+1 with wrap → grant, OWN.
  - No candidate → stay IDLE.
- OWN: RAM port = owner's m_* signals, passed combinationally.
  - Exit to DRAIN when req[owner]=0.
  - MODE 0 also exits when sel≠owner.
  - On exit, grant clears in the same edge.
- DRAIN: RAM port idle. Counter runs READ_LAT cycles, then IDLE. last_owner=owner.
- Ungranted masters never reach the RAM. Their ce/wre are ignored, not errors.
- Idle RAM port (no grant): ram_ce=0, ram_wre=0, ram_oce=1, ram_ad=0, ram_din=0.
- Read tracking: a READ_LAT-deep shift register of {valid, owner id}.
  - Entry is pushed when grant active and m_ce[owner]&~m_wre[owner].
  - On pop, m_rvalid[id] pulses.
- Writes produce no rvalid.

## Timing
- Reset values: grant=0, m_rvalid=0, state=IDLE, last_owner=N_MASTERS-1, shift register cleared.
- RAM outputs after reset take the idle values.
- Grant latency: req/sel seen at edge t → grant high after edge t, so the master's first access is in cycle t+1.
- Read: issued in cycle c → m_rvalid[k] high and rdata valid in cycle c+READ_LAT, exactly one cycle.
- Back-to-back reads give one rvalid per cycle.
- Hand-over gap: req drop seen at edge t → grant low after t. Next grant is asserted no earlier than edge t+READ_LAT+1.
- rvalid of the old owner still pulses during DRAIN. It is never attributed to the new owner.
- A master that drops req in the same cycle it issues a read gets that read: the access is still passed and tracked.
- A master that re-raises req during DRAIN waits for IDLE. In MODE 1 it has the lowest priority if others are requesting.
- MODE 0, sel out of range: no grant. An owner in OWN goes to DRAIN.
- rst mid-operation: grant drops immediately (async), in-flight rvalids are discarded, RAM port goes idle.

## Structure
- Shared package: MODE_SELECT/MODE_RR constants and the FSM state encoding (2-bit IDLE=0, OWN=1, DRAIN=2).
- Sub-module rd_tag_pipe (READ_LAT-deep valid+id shift register): reused by the adc buffer front end.
- Round-robin picker stays inline.

## Test plan
- MODE 0, N=3, READ_LAT=2: req[1]=1, sel=1 → grant=3'b010 next cycle. Read at ad 11'h005 → m_rvalid[1] two cycles later, rdata = stored word.
- Hand-over: master 1 reads in its last cycle, drops req, sel→2 → m_rvalid[1] pulses during DRAIN. grant[2] rises exactly 3 cycles after grant[1] falls. m_rvalid[2] never fires for the old read.
- MODE 1, all three req held high with 1-cycle release pulses → grants rotate 0→1→2→0. No grant overlap, ram_ce never driven by an ungranted master.
- Write 32'hDEADBEEF at 11'h3FF by master 0, read back by master 2 → m_rvalid[2] with matching rdata. No rvalid for the write.
- sel=3 with N=3 → grant stays 0, ram_ce=0.
- rst asserted mid-read → grant=0 and m_rvalid=0 immediately, no pulse after release.

Source files
------------

// File: rtl/sp_port_arbiter_pkg.sv
// Shared constants for the single-port RAM arbiter: ownership modes and FSM encoding.
package sp_port_arbiter_pkg;

    localparam int MODE_SELECT = 0;  // ownership follows the external sel input
    localparam int MODE_RR     = 1;  // ownership rotates over requesting masters

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sp_port_arbiter_rd_tag_pipe.sv
// Read tag pipeline: carries {valid, master id} for every issued read so the
// returning RAM data can be attributed to the master that issued it.
module rd_tag_pipe #(
    parameter int LAT  = 2,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_vld,
    input  logic [ID_W-1:0] push_id,
    output logic            pop_vld,
    output logic [ID_W-1:0] pop_id
);

    logic [LAT-1:0]           vld_q, vld_d;
    logic [LAT-1:0][ID_W-1:0] id_q, id_d;

    // Shift one stage per cycle; stage 0 loads the read issued this cycle.
    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = push_vld;
        id_d[0]  = push_id;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    // Pipeline registers; reset discards every read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign pop_vld = vld_q[LAT-1];
    assign pop_id  = id_q[LAT-1];

endmodule

// File: rtl/sp_port_arbiter.sv
// N-master front end for one single-port block RAM. One master owns the port at
// a time; ownership changes only after a drain of READ_LAT cycles so that read
// data in flight always returns to the master that asked for it.
module sp_port_arbiter
    import sp_port_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 2,
    parameter int MODE      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(N_MASTERS)-1:0]  sel,
    input  logic [N_MASTERS-1:0]          req,
    output logic [N_MASTERS-1:0]          grant,
    input  logic [N_MASTERS-1:0]          m_oce,
    input  logic [N_MASTERS-1:0]          m_ce,
    input  logic [N_MASTERS-1:0]          m_wre,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_ad,
    input  logic [N_MASTERS*DATA_W-1:0]   m_din,
    output logic [N_MASTERS-1:0]          m_rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic                          ram_oce,
    output logic                          ram_ce,
    output logic                          ram_wre,
    output logic [ADDR_W-1:0]             ram_ad,
    output logic [DATA_W-1:0]             ram_din,
    input  logic [DATA_W-1:0]             ram_dout
);

    localparam int ID_W  = $clog2(N_MASTERS);
    localparam int CNT_W = $clog2(READ_LAT) + 1;

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [ID_W-1:0]       last_owner_q, last_owner_d;
    logic [N_MASTERS-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  sel_ok;
    logic                  rr_found;
    logic [ID_W-1:0]       rr_idx;
    int                    rr_k;
    logic                  issue_rd;
    logic                  pop_vld;
    logic [ID_W-1:0]       pop_id;

    // sel can encode more values than there are masters; those select nobody.
    assign sel_ok = (int'(sel) < N_MASTERS);

    // Round-robin pick: scan from farthest to nearest after last_owner so the
    // nearest requester wins; the previous owner therefore ranks last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_k     = 0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            rr_k = (int'(last_owner_q) + i) % N_MASTERS;
            if (req[rr_k]) begin
                rr_found = 1'b1;
                rr_idx   = ID_W'(rr_k);
            end
        end
    end

    // Ownership FSM: grant in IDLE, release on req drop (or sel move), drain.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (MODE == MODE_SELECT) begin
                    if (sel_ok && req[sel]) begin
                        owner_d = sel;
                        grant_d = N_MASTERS'(1) << sel;
                        state_d = ST_OWN;
                    end
                end else if (rr_found) begin
                    owner_d = rr_idx;
                    grant_d = N_MASTERS'(1) << rr_idx;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!req[owner_q] || (MODE == MODE_SELECT && sel != owner_q)) begin
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    cnt_d        = '0;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // FSM state, owner bookkeeping and registered grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= ID_W'(N_MASTERS - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign grant = grant_q;

    // RAM port: owner's controls pass straight through; idle values otherwise.
    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_oce = 1'b1;
        ram_ad  = '0;
        ram_din = '0;
        if (|grant_q) begin
            ram_ce  = m_ce[owner_q];
            ram_wre = m_wre[owner_q];
            ram_oce = m_oce[owner_q];
            ram_ad  = m_ad[owner_q*ADDR_W +: ADDR_W];
            ram_din = m_din[owner_q*DATA_W +: DATA_W];
        end
    end

    // A read is tracked even in the cycle its master drops req: grant is still high.
    assign issue_rd = (|grant_q) & m_ce[owner_q] & ~m_wre[owner_q];

    rd_tag_pipe #(
        .LAT  (READ_LAT),
        .ID_W (ID_W)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .push_vld (issue_rd),
        .push_id  (owner_q),
        .pop_vld  (pop_vld),
        .pop_id   (pop_id)
    );

    // Decode the returning tag into a one-cycle per-master valid pulse.
    always_comb begin
        m_rvalid = '0;
        if (pop_vld) begin
            m_rvalid = N_MASTERS'(1) << pop_id;
        end
    end

    assign rdata = ram_dout;

endmodule

// File: tb/tb_sp_port_arbiter.sv
// Randomized bench: one select-mode and one round-robin instance, each with its
// own behavioural RAM and a cycle-level reference model of ownership and reads.
module tb_sp_port_arbiter;

    localparam int N   = 3;
    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      sel      [2];
    logic [N-1:0]    req      [2];
    logic [N-1:0]    grant    [2];
    logic [N-1:0]    m_oce    [2];
    logic [N-1:0]    m_ce     [2];
    logic [N-1:0]    m_wre    [2];
    logic [N*AW-1:0] m_ad     [2];
    logic [N*DW-1:0] m_din    [2];
    logic [N-1:0]    m_rvalid [2];
    logic [DW-1:0]   rdata    [2];
    logic            ram_oce  [2];
    logic            ram_ce   [2];
    logic            ram_wre  [2];
    logic [AW-1:0]   ram_ad   [2];
    logic [DW-1:0]   ram_din  [2];
    logic [DW-1:0]   ram_dout [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sp_port_arbiter #(
            .N_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .READ_LAT (LAT), .MODE (g)
        ) u_dut (
            .clk (clk), .rst (rst), .sel (sel[g]), .req (req[g]), .grant (grant[g]),
            .m_oce (m_oce[g]), .m_ce (m_ce[g]), .m_wre (m_wre[g]), .m_ad (m_ad[g]),
            .m_din (m_din[g]), .m_rvalid (m_rvalid[g]), .rdata (rdata[g]),
            .ram_oce (ram_oce[g]), .ram_ce (ram_ce[g]), .ram_wre (ram_wre[g]),
            .ram_ad (ram_ad[g]), .ram_din (ram_din[g]), .ram_dout (ram_dout[g])
        );

        // Behavioural single-port RAM with LAT cycles of read latency.
        logic [DW-1:0] mem  [0:2047];
        logic [DW-1:0] pipe [0:LAT-1];
        initial begin
            for (int i = 0; i < 2048; i++) mem[i] = '0;
            for (int i = 0; i < LAT; i++) pipe[i] = '0;
        end
        always @(posedge clk) begin
            if (ram_ce[g] && ram_wre[g]) mem[ram_ad[g]] <= ram_din[g];
            pipe[0] <= mem[ram_ad[g]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_dout[g] = pipe[LAT-1];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), hold-off cycles after a release,
    // rotation pointer, own memory image and a due-cycle table of read returns.
    int          own  [2];
    int          last [2];
    int          hold [2];
    logic [DW-1:0] mmem [2][0:2047];
    logic        ev   [2][8];
    int          eid  [2][8];
    logic [DW-1:0] edat [2][8];
    int          cyc;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            own[d]  = -1;
            last[d] = N - 1;
            hold[d] = 0;
            for (int s = 0; s < 8; s++) begin
                ev[d][s] = 1'b0; eid[d][s] = 0; edat[d][s] = '0;
            end
        end
    endtask

    task automatic check_cycle(input int d);
        int s;
        logic [N-1:0] eg, erv;
        s   = cyc % 8;
        eg  = (own[d] >= 0) ? N'(1 << own[d]) : '0;
        erv = ev[d][s] ? N'(1 << eid[d][s]) : '0;
        chk($sformatf("d%0d grant", d), 64'(grant[d]), 64'(eg));
        chk($sformatf("d%0d rvalid", d), 64'(m_rvalid[d]), 64'(erv));
        if (ev[d][s]) chk($sformatf("d%0d rdata", d), 64'(rdata[d]), 64'(edat[d][s]));
        if (own[d] >= 0) begin
            chk($sformatf("d%0d ram_ce", d), 64'(ram_ce[d]), 64'(m_ce[d][own[d]]));
            chk($sformatf("d%0d ram_wre", d), 64'(ram_wre[d]), 64'(m_wre[d][own[d]]));
            chk($sformatf("d%0d ram_oce", d), 64'(ram_oce[d]), 64'(m_oce[d][own[d]]));
            chk($sformatf("d%0d ram_ad", d), 64'(ram_ad[d]), 64'(m_ad[d][own[d]*AW +: AW]));
            chk($sformatf("d%0d ram_din", d), 64'(ram_din[d]), 64'(m_din[d][own[d]*DW +: DW]));
        end else begin
            chk($sformatf("d%0d idle ram_ce", d), 64'(ram_ce[d]), 64'd0);
            chk($sformatf("d%0d idle ram_wre", d), 64'(ram_wre[d]), 64'd0);
            chk($sformatf("d%0d idle ram_oce", d), 64'(ram_oce[d]), 64'd1);
            chk($sformatf("d%0d idle ram_ad", d), 64'(ram_ad[d]), 64'd0);
            chk($sformatf("d%0d idle ram_din", d), 64'(ram_din[d]), 64'd0);
        end
    endtask

    // Advance the model across one clock edge using the inputs of this cycle.
    task automatic model_step(input int d);
        int a, o, k;
        ev[d][cyc % 8] = 1'b0;
        if (own[d] >= 0) begin
            o = own[d];
            a = int'(m_ad[d][o*AW +: AW]);
            if (m_ce[d][o]) begin
                if (m_wre[d][o]) begin
                    mmem[d][a] = m_din[d][o*DW +: DW];
                end else begin
                    ev[d][(cyc + LAT) % 8]   = 1'b1;
                    eid[d][(cyc + LAT) % 8]  = o;
                    edat[d][(cyc + LAT) % 8] = mmem[d][a];
                end
            end
            if (!req[d][o] || (d == 0 && int'(sel[d]) != o)) begin
                last[d] = o;
                own[d]  = -1;
                hold[d] = LAT;
            end
        end else if (hold[d] > 0) begin
            hold[d]--;
        end else if (d == 0) begin
            if (int'(sel[d]) < N && req[d][sel[d]]) own[d] = int'(sel[d]);
        end else begin
            for (int i = 1; i <= N; i++) begin
                k = (last[d] + i) % N;
                if (own[d] < 0 && req[d][k]) own[d] = k;
            end
        end
    endtask

    task automatic drive(input int d);
        for (int k = 0; k < N; k++) begin
            if (req[d][k]) begin
                if ($urandom_range(9) == 0) req[d][k] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                req[d][k] = 1'b1;
            end
            m_ad[d][k*AW +: AW]  = ($urandom_range(3) == 0) ? 11'h3FF : AW'($urandom_range(15));
            m_din[d][k*DW +: DW] = ($urandom_range(7) == 0) ? 32'hDEADBEEF : $urandom;
        end
        if ($urandom_range(9) == 0) sel[d] = 2'($urandom_range(3));
        m_ce[d]  = N'($urandom);
        m_wre[d] = N'($urandom & $urandom);
        m_oce[d] = N'($urandom);
    endtask

    logic rst_cyc;

    initial begin
        for (int d = 0; d < 2; d++) begin
            sel[d] = '0; req[d] = '0; m_oce[d] = '0; m_ce[d] = '0; m_wre[d] = '0;
            m_ad[d] = '0; m_din[d] = '0;
            for (int i = 0; i < 2048; i++) mmem[d][i] = '0;
        end
        cyc = 0;
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) check_cycle(d);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst     = 1'b0;
            rst_cyc = 1'b0;
            cyc     = c;
            for (int d = 0; d < 2; d++) drive(d);
            #1;
            for (int d = 0; d < 2; d++) check_cycle(d);
            if (c == 700 || c == 1800) begin
                rst = 1'b1;
                rst_cyc = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("d%0d rst grant", d), 64'(grant[d]), 64'd0);
                    chk($sformatf("d%0d rst rvalid", d), 64'(m_rvalid[d]), 64'd0);
                    chk($sformatf("d%0d rst ram_ce", d), 64'(ram_ce[d]), 64'd0);
                end
                model_reset();
            end
            @(posedge clk);
            if (!rst_cyc) for (int d = 0; d < 2; d++) model_step(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
